// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control sequencer: walks each instruction through fetch/decode/execute/
// memory/writeback, driving datapath selects and strobes, plus cycle/instruction counters.
module multicycle_control #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [5:0]       op,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             ir_write,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_dest,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [3:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_MEM_ADDR  = 4'd2;
    localparam logic [3:0] S_MEM_READ  = 4'd3;
    localparam logic [3:0] S_MEM_WB    = 4'd4;
    localparam logic [3:0] S_MEM_WRITE = 4'd5;
    localparam logic [3:0] S_EXEC      = 4'd6;
    localparam logic [3:0] S_R_WB      = 4'd7;
    localparam logic [3:0] S_BRANCH    = 4'd8;
    localparam logic [3:0] S_JUMP      = 4'd9;
    localparam logic [3:0] S_ADDI_EX   = 4'd10;
    localparam logic [3:0] S_ADDI_WB   = 4'd11;
    localparam logic [3:0] S_HALT      = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    logic [3:0]       r_state;
    logic [3:0]       w_next;
    logic             r_illegal;
    logic [CNT_W-1:0] r_cycle_count;
    logic [CNT_W-1:0] r_instr_count;
    logic             w_pc_write;
    logic             w_ir_write;
    logic             w_mem_write;
    logic             w_reg_write;

    // State register
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; unreachable encodings fall into HALT
    always_comb begin
        w_next = S_HALT;
        case (r_state)
            S_FETCH:     w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: w_next = S_MEM_ADDR;
                    OP_RTYPE:     w_next = S_EXEC;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_J:         w_next = S_JUMP;
                    OP_ADDI:      w_next = S_ADDI_EX;
                    default:      w_next = S_HALT;
                endcase
            end
            S_MEM_ADDR:  w_next = (op == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  w_next = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WB:    w_next = S_FETCH;
            S_MEM_WRITE: w_next = mem_ready ? S_FETCH : S_MEM_WRITE;
            S_EXEC:      w_next = S_R_WB;
            S_R_WB:      w_next = S_FETCH;
            S_BRANCH:    w_next = S_FETCH;
            S_JUMP:      w_next = S_FETCH;
            S_ADDI_EX:   w_next = S_ADDI_WB;
            S_ADDI_WB:   w_next = S_FETCH;
            S_HALT:      w_next = S_HALT;
            default:     w_next = S_HALT;
        endcase
    end

    // Per-state datapath controls; FETCH and BRANCH carry Mealy strobes
    always_comb begin
        w_pc_write  = 1'b0;
        pc_src      = 2'b00;
        w_ir_write  = 1'b0;
        i_or_d      = 1'b0;
        mem_read    = 1'b0;
        w_mem_write = 1'b0;
        reg_dest    = 1'b0;
        mem_to_reg  = 1'b0;
        w_reg_write = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_op      = 2'b00;
        case (r_state)
            S_FETCH: begin
                mem_read   = 1'b1;
                alu_src_b  = 2'b01;
                w_ir_write = mem_ready;
                w_pc_write = mem_ready;
            end
            S_DECODE:    alu_src_b = 2'b11;
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                w_reg_write = 1'b1;
                mem_to_reg  = 1'b1;
            end
            S_MEM_WRITE: begin
                w_mem_write = 1'b1;
                i_or_d      = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_R_WB: begin
                w_reg_write = 1'b1;
                reg_dest    = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b01;
                pc_src     = 2'b01;
                w_pc_write = zero;
            end
            S_JUMP: begin
                pc_src     = 2'b10;
                w_pc_write = 1'b1;
            end
            S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_ADDI_WB:   w_reg_write = 1'b1;
            default:     w_pc_write = 1'b0;
        endcase
    end

    // Reset suppresses every architectural write in the cycle it is asserted
    assign pc_write  = w_pc_write  & ~clr;
    assign ir_write  = w_ir_write  & ~clr;
    assign mem_write = w_mem_write & ~clr;
    assign reg_write = w_reg_write & ~clr;

    // Sticky illegal flag, set on the edge that enters HALT
    always_ff @(posedge clk) begin
        if (clr) begin
            r_illegal <= 1'b0;
        end else if (w_next == S_HALT) begin
            r_illegal <= 1'b1;
        end else begin
            r_illegal <= r_illegal;
        end
    end

    // Cycle counter freezes in HALT; instruction counter follows IR loads
    always_ff @(posedge clk) begin
        if (clr) begin
            r_cycle_count <= '0;
            r_instr_count <= '0;
        end else begin
            if (r_state != S_HALT) begin
                r_cycle_count <= r_cycle_count + CNT_W'(1);
            end else begin
                r_cycle_count <= r_cycle_count;
            end
            if (ir_write) begin
                r_instr_count <= r_instr_count + CNT_W'(1);
            end else begin
                r_instr_count <= r_instr_count;
            end
        end
    end

    assign state       = r_state;
    assign illegal     = r_illegal;
    assign cycle_count = r_cycle_count;
    assign instr_count = r_instr_count;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: stimulus pushes hand-derived per-cycle
// expectations, a negedge monitor pops and compares them against the DUT.
module tb_multicycle_control;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          clr = 1'b1;
    logic [5:0]    op = 6'h00;
    logic          zero = 1'b0;
    logic          mem_ready = 1'b1;
    logic          pc_write, ir_write, i_or_d, mem_read, mem_write;
    logic          reg_dest, mem_to_reg, reg_write, alu_src_a, illegal;
    logic [1:0]    pc_src, alu_src_b, alu_op;
    logic [3:0]    state;
    logic [CW-1:0] cycle_count, instr_count;

    multicycle_control #(.CNT_W(CW)) dut (
        .clk(clk), .clr(clr), .op(op), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .reg_dest(reg_dest),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .state(state), .illegal(illegal),
        .cycle_count(cycle_count), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] R = 6'h00, LW = 6'h23, SW = 6'h2B, BEQ = 6'h04, J = 6'h02,
                           ADDI = 6'h08, BAD = 6'h3F;

    typedef struct {
        logic [3:0]    st;
        logic [14:0]   ctrl;
        logic          ill;
        logic [CW-1:0] cyc;
        logic [CW-1:0] ins;
    } exp_t;

    exp_t q[$];
    int n_pass = 0;
    int n_tot  = 0;
    logic [CW-1:0] m_cyc = '0;
    logic [CW-1:0] m_ins = '0;

    // {pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write, reg_dest, mem_to_reg,
    //  reg_write, alu_src_a, alu_src_b, alu_op}
    wire [14:0] act_ctrl = {pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write,
                            reg_dest, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op};

    function automatic logic [14:0] ctrl_for(input logic [3:0] s, input logic z,
                                             input logic mr, input logic c);
        logic [14:0] w;
        case (s)
            4'd0:  w = {mr, 2'b00, mr, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00};
            4'd1:  w = 15'b000_0000_0000_1100;
            4'd2:  w = 15'b000_0000_0001_1000;
            4'd3:  w = 15'b000_0110_0000_0000;
            4'd4:  w = 15'b000_0000_0110_0000;
            4'd5:  w = 15'b000_0101_0000_0000;
            4'd6:  w = 15'b000_0000_0001_0010;
            4'd7:  w = 15'b000_0000_1010_0000;
            4'd8:  w = {z, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01};
            4'd9:  w = 15'b110_0000_0000_0000;
            4'd10: w = 15'b000_0000_0001_1000;
            4'd11: w = 15'b000_0000_0010_0000;
            default: w = 15'd0;
        endcase
        if (c) begin
            w[14] = 1'b0;
            w[11] = 1'b0;
            w[8]  = 1'b0;
            w[5]  = 1'b0;
        end
        return w;
    endfunction

    task automatic step(input logic c, input logic [5:0] o, input logic z,
                        input logic mr, input logic [3:0] es);
        exp_t e;
        @(posedge clk);
        #1;
        clr = c; op = o; zero = z; mem_ready = mr;
        e.st   = es;
        e.ctrl = ctrl_for(es, z, mr, c);
        e.ill  = (es == 4'd12);
        e.cyc  = m_cyc;
        e.ins  = m_ins;
        q.push_back(e);
        if (c) begin
            m_cyc = '0;
            m_ins = '0;
        end else begin
            if (es != 4'd12) m_cyc = m_cyc + 4'd1;
            if (e.ctrl[11])  m_ins = m_ins + 4'd1;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp)
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        else
            n_pass++;
    endtask

    // Monitor: compare every presented cycle against the queued expectation
    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk("state", {28'd0, state}, {28'd0, e.st});
            chk("ctrl", {17'd0, act_ctrl}, {17'd0, e.ctrl});
            chk("illegal", {31'd0, illegal}, {31'd0, e.ill});
            chk("cycle_count", {28'd0, cycle_count}, {28'd0, e.cyc});
            chk("instr_count", {28'd0, instr_count}, {28'd0, e.ins});
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        // reset held three cycles with memory ready
        repeat (3) step(1'b1, R, 1'b0, 1'b1, 4'd0);
        // R-type then lw
        step(0, R, 0, 1, 0);  step(0, R, 0, 1, 1);  step(0, R, 0, 1, 6);  step(0, R, 0, 1, 7);
        step(0, LW, 0, 1, 0); step(0, LW, 0, 1, 1); step(0, LW, 0, 1, 2);
        step(0, LW, 0, 1, 3); step(0, LW, 0, 1, 4);
        // beq taken and not taken
        step(0, BEQ, 1, 1, 0); step(0, BEQ, 1, 1, 1); step(0, BEQ, 1, 1, 8);
        step(0, BEQ, 0, 1, 0); step(0, BEQ, 0, 1, 1); step(0, BEQ, 0, 1, 8);
        // sw with two memory wait cycles
        step(0, SW, 0, 1, 0); step(0, SW, 0, 1, 1); step(0, SW, 0, 1, 2);
        step(0, SW, 0, 0, 5); step(0, SW, 0, 0, 5); step(0, SW, 0, 1, 5);
        // fetch wait then addi
        step(0, ADDI, 0, 0, 0); step(0, ADDI, 0, 1, 0); step(0, ADDI, 0, 1, 1);
        step(0, ADDI, 0, 1, 10); step(0, ADDI, 0, 1, 11);
        // reset during a lw memory wait
        step(0, LW, 0, 1, 0); step(0, LW, 0, 1, 1); step(0, LW, 0, 1, 2);
        step(0, LW, 0, 0, 3); step(1, LW, 0, 0, 3);
        // illegal opcode halts, reset recovers
        step(0, BAD, 0, 1, 0); step(0, BAD, 0, 1, 1);
        step(0, BAD, 0, 1, 12); step(0, BAD, 0, 1, 12); step(0, BAD, 0, 1, 12);
        step(1, BAD, 0, 1, 12);
        step(0, J, 0, 1, 0);
        // counter wrap: restart counters, then 16 jumps
        step(0, J, 0, 1, 1);  step(1, J, 0, 1, 9);
        for (int k = 0; k < 16; k++) begin
            step(0, J, 0, 1, 0); step(0, J, 0, 1, 1); step(0, J, 0, 1, 9);
        end
        step(0, J, 0, 0, 0);
        step(0, J, 0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        if (q.size() != 0) begin
            n_tot++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
